// File: rtl/num_conv_ctrl.sv
// Button-driven binary-to-BCD converter: synchronised key edges start an iterative
// double-dabble (one add-3 or shift phase per clock) and latch a 3-digit result.
module num_conv_ctrl #(
    parameter int WIDTH     = 8,
    parameter int OVF_LIMIT = 99
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             KEY1,
    input  logic             KEY0,
    input  logic [WIDTH-1:0] switches,
    output logic [11:0]      bcd_out,
    output logic             overflow,
    output logic             busy,
    output logic             done,
    output logic             valid
);

    localparam logic [WIDTH-1:0] OVF_L = WIDTH'(OVF_LIMIT);

    typedef enum logic [2:0] {IDLE, LOAD, ADJ, SHIFT, DONE} state_t;

    state_t           state;
    logic             k1_s1, k1_s2, k0_s1, k0_s2;
    logic             conv_req, clr_req;
    logic [WIDTH-1:0] bin_sh;
    logic [WIDTH-1:0] op;
    logic [11:0]      bcd_sh;
    logic [3:0]       cnt;

    // Each BCD digit of 5 or more gets +3 so the following shift carries into the next digit.
    function automatic logic [11:0] add3_digits(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        for (int i = 0; i < 3; i++) begin
            if (v[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = v[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    // Keys idle high; registered press-edge detect yields one pulse per press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k1_s1    <= 1'b1;
            k1_s2    <= 1'b1;
            k0_s1    <= 1'b1;
            k0_s2    <= 1'b1;
            conv_req <= 1'b0;
            clr_req  <= 1'b0;
        end else begin
            k1_s1    <= KEY1;
            k1_s2    <= k1_s1;
            k0_s1    <= KEY0;
            k0_s2    <= k0_s1;
            conv_req <= ~k1_s1 & k1_s2;
            clr_req  <= ~k0_s1 & k0_s2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            bin_sh   <= '0;
            op       <= '0;
            bcd_sh   <= '0;
            cnt      <= '0;
            bcd_out  <= '0;
            overflow <= 1'b0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else if (clr_req) begin
            state    <= IDLE;
            bcd_out  <= '0;
            overflow <= 1'b0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (conv_req) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    bin_sh <= switches;
                    op     <= switches;
                    bcd_sh <= '0;
                    cnt    <= 4'(WIDTH);
                    state  <= ADJ;
                end
                ADJ: begin
                    bcd_sh <= add3_digits(bcd_sh);
                    state  <= SHIFT;
                end
                SHIFT: begin
                    {bcd_sh, bin_sh} <= {bcd_sh[10:0], bin_sh, 1'b0};
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state <= ADJ;
                    end
                end
                DONE: begin
                    bcd_out  <= bcd_sh;
                    overflow <= (op > OVF_L);
                    valid    <= 1'b1;
                    done     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_num_conv_ctrl.sv
// Directed bench for num_conv_ctrl: conversions, boundary operands, dropped requests,
// clear mid-conversion, simultaneous keys and asynchronous reset.
module tb_num_conv_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        KEY1, KEY0;
    logic [7:0]  switches;
    logic [11:0] bcd_out;
    logic        overflow, busy, done, valid;

    int errors = 0;
    int checks = 0;

    num_conv_ctrl #(.WIDTH(8), .OVF_LIMIT(99)) dut (
        .clk(clk), .rst_n(rst_n), .KEY1(KEY1), .KEY0(KEY0), .switches(switches),
        .bcd_out(bcd_out), .overflow(overflow), .busy(busy), .done(done), .valid(valid)
    );

    always #5 clk = ~clk;

    // Press KEY1 with the given operand and wait for busy; returns 1 if busy was seen.
    task automatic start_conv(input logic [7:0] val, output bit started);
        started = 0;
        @(negedge clk);
        switches = val;
        KEY1 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 3) KEY1 = 1'b1;
            if (busy) begin
                started = 1;
                break;
            end
        end
        KEY1 = 1'b1;
    endtask

    // After busy was seen (LOAD cycle), count negedges until done; 99 on timeout.
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!done && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
        if (!done) cycles = 99;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; KEY1 = 1'b1; KEY0 = 1'b1; switches = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if ({bcd_out, overflow, busy, done, valid} !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs: got bcd=%h ovf=%b busy=%b done=%b valid=%b, want all 0",
                     bcd_out, overflow, busy, done, valid);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_release: got busy=%b valid=%b, want 0 0", busy, valid);
        end
    endtask

    task automatic run_and_check(input string name, input logic [7:0] val,
                                 input logic [11:0] exp_bcd, input logic exp_ovf);
        bit started;
        int lat;
        start_conv(val, started);
        checks++;
        if (!started) begin
            errors++;
            $display("FAIL %s_start: busy never rose, want busy=1", name);
            return;
        end
        wait_done(lat);
        checks++;
        if (lat != 17) begin
            errors++;
            $display("FAIL %s_latency: got %0d cycles from LOAD to done, want 17", name, lat);
        end
        @(negedge clk);
        checks++;
        if (bcd_out !== exp_bcd || overflow !== exp_ovf || valid !== 1'b1 ||
            done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_result: got bcd=%h ovf=%b valid=%b done=%b busy=%b, want bcd=%h ovf=%b valid=1 done=0 busy=0",
                     name, bcd_out, overflow, valid, done, busy, exp_bcd, exp_ovf);
        end
    endtask

    task automatic test_basic;
        run_and_check("conv_2a", 8'h2A, 12'h042, 1'b0);
    endtask

    task automatic test_boundary;
        run_and_check("conv_00", 8'h00, 12'h000, 1'b0);
        run_and_check("conv_63", 8'h63, 12'h099, 1'b0);
        run_and_check("conv_64", 8'h64, 12'h100, 1'b1);
        run_and_check("conv_ff", 8'hFF, 12'h255, 1'b1);
    endtask

    task automatic test_drop_while_busy;
        bit started;
        int dones = 0;
        int busy_rises = 0;
        logic busy_prev;
        start_conv(8'h10, started);
        checks++;
        if (!started) begin
            errors++;
            $display("FAIL drop_start: busy never rose, want busy=1");
            return;
        end
        busy_prev = 1'b1;
        for (int i = 1; i < 60; i++) begin
            @(negedge clk);
            if (i == 4) begin
                switches = 8'hFF;
                KEY1 = 1'b0;
            end
            if (i == 8) KEY1 = 1'b1;
            if (done) dones++;
            if (busy && !busy_prev) busy_rises++;
            busy_prev = busy;
        end
        checks++;
        if (dones != 1 || busy_rises != 0) begin
            errors++;
            $display("FAIL drop_count: got dones=%0d restarts=%0d, want 1 0", dones, busy_rises);
        end
        checks++;
        if (bcd_out !== 12'h016 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL drop_result: got bcd=%h ovf=%b, want 016 0", bcd_out, overflow);
        end
    endtask

    task automatic test_clear_mid;
        bit started;
        bit dropped = 0;
        int dones = 0;
        start_conv(8'h50, started);
        checks++;
        if (!started) begin
            errors++;
            $display("FAIL clear_start: busy never rose, want busy=1");
            return;
        end
        for (int i = 1; i < 20; i++) begin
            @(negedge clk);
            if (i == 6) KEY0 = 1'b0;
            if (i == 10) KEY0 = 1'b1;
            if (done) dones++;
            if (!busy && !dropped) begin
                dropped = 1;
                checks++;
                if (i < 7 || i > 10) begin
                    errors++;
                    $display("FAIL clear_busy_drop: busy fell at cycle %0d, want 7..10", i);
                end
            end
        end
        KEY0 = 1'b1;
        checks++;
        if (!dropped || dones != 0) begin
            errors++;
            $display("FAIL clear_abort: got busy_dropped=%b dones=%0d, want 1 0", dropped, dones);
        end
        checks++;
        if (bcd_out !== 12'h000 || valid !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL clear_outputs: got bcd=%h valid=%b ovf=%b, want 000 0 0",
                     bcd_out, valid, overflow);
        end
    endtask

    task automatic test_both_keys;
        int busy_seen = 0;
        run_and_check("pre_both", 8'h07, 12'h007, 1'b0);
        @(negedge clk);
        switches = 8'h55;
        KEY1 = 1'b0;
        KEY0 = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (i == 4) begin
                KEY1 = 1'b1;
                KEY0 = 1'b1;
            end
            if (busy || done) busy_seen++;
        end
        checks++;
        if (busy_seen != 0) begin
            errors++;
            $display("FAIL both_no_start: got %0d busy/done cycles, want 0", busy_seen);
        end
        checks++;
        if (bcd_out !== 12'h000 || valid !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL both_cleared: got bcd=%h valid=%b ovf=%b, want 000 0 0",
                     bcd_out, valid, overflow);
        end
    endtask

    task automatic test_async_reset;
        bit started;
        run_and_check("pre_rst", 8'h33, 12'h051, 1'b0);
        start_conv(8'h80, started);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bcd_out, overflow, busy, done, valid} !== 16'h0) begin
            errors++;
            $display("FAIL async_reset: got bcd=%h ovf=%b busy=%b done=%b valid=%b, want all 0",
                     bcd_out, overflow, busy, done, valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_and_check("post_rst_09", 8'h09, 12'h009, 1'b0);
    endtask

    initial begin
        test_reset;
        test_basic;
        test_boundary;
        test_drop_while_busy;
        test_clear_mid;
        test_both_keys;
        test_async_reset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
